pkt_rr_arbiter: RTL



---
 rtl/sw_pkg.sv | 25 ++
 rtl/pkt_rr_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 30 +++
 rtl/pkt_rr_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Definitions shared across the switch egress path: framing bytes,
// arbiter state encoding and small index helpers.
package sw_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hFF;
  localparam logic [7:0] DELIMITER = 8'h55;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slot visited at step off of a round-robin scan that starts after base.
  function automatic int unsigned rr_slot(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_if.sv
// Bundle between the ingress FIFOs, the egress output FSM and the packet
// arbiter that shares the FSM between them.
interface pkt_rr_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W_WIDTH = 8
);

  logic                       sw_en;
  logic [N_REQ-1:0]           req_empty;
  logic [N_REQ*W_WIDTH-1:0]   fifo_data_in;
  logic [N_REQ-1:0]           fifo_rd_en;
  logic                       out_rd_en;
  logic                       out_empty;
  logic [W_WIDTH-1:0]         out_fifo_data;
  logic [N_REQ-1:0]           grant;
  logic                       busy;
  logic                       pkt_done;
  logic                       timeout_err;

  // Arbiter side.
  modport master (
    input  sw_en, req_empty, fifo_data_in, out_rd_en,
    output fifo_rd_en, out_empty, out_fifo_data, grant, busy, pkt_done,
           timeout_err
  );

  // FIFO / output FSM / status side.
  modport slave (
    output sw_en, req_empty, fifo_data_in, out_rd_en,
    input  fifo_rd_en, out_empty, out_fifo_data, grant, busy, pkt_done,
           timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester found scanning upward
// from the slot after last_grant, wrapping at N_REQ.
module rr_pick
  import sw_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx
);

  logic [IW-1:0] slot;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    slot     = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      slot = IW'(rr_slot(32'(last_grant), off, N_REQ));
      if ((pick == '0) && req[slot]) begin
        pick[slot] = 1'b1;
        pick_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: one ingress FIFO owns the egress output
// FSM from grant until its delimiter byte is popped or the read watchdog expires.
module pkt_rr_arbiter
  import sw_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input logic              clk,
  input logic              rst,
  pkt_rr_arbiter_if.master bus
);

  localparam int unsigned        IW      = idx_width(N_REQ);
  localparam int unsigned        CW      = idx_width(TIMEOUT_CYC);
  localparam logic [CW-1:0]      WD_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [W_WIDTH-1:0] DELIM_W = W_WIDTH'(DELIMITER);

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      wd_q, wd_d;
  logic               pkt_done_q, pkt_done_d;
  logic               tmo_q, tmo_d;

  logic [N_REQ-1:0]   req_vec;
  logic [N_REQ-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;
  logic [W_WIDTH-1:0] data_mux;
  logic               pop_delim;

  assign req_vec = ~bus.req_empty;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req        (req_vec),
    .last_grant (last_q),
    .pick       (pick_oh),
    .pick_idx   (pick_idx)
  );

  // AND-OR mux keyed directly on the one-hot grant; zero grant yields idle values.
  always_comb begin
    data_mux = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        data_mux = data_mux | bus.fifo_data_in[i*W_WIDTH +: W_WIDTH];
      end
    end
  end

  assign bus.out_fifo_data = data_mux;
  assign bus.out_empty     = ~|(grant_q & req_vec);
  assign bus.fifo_rd_en    = grant_q & {N_REQ{bus.out_rd_en}};
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q == GRANTED);
  assign bus.pkt_done      = pkt_done_q;
  assign bus.timeout_err   = tmo_q;

  assign pop_delim = bus.out_rd_en && (data_mux == DELIM_W);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    wd_d       = wd_q;
    pkt_done_d = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sw_en && (pick_oh != '0)) begin
          state_d = GRANTED;
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          wd_d    = '0;
        end
      end
      GRANTED: begin
        // Delimiter pop wins over a watchdog expiry in the same cycle.
        if (pop_delim) begin
          state_d    = IDLE;
          grant_d    = '0;
          last_d     = gidx_q;
          pkt_done_d = 1'b1;
        end else if (bus.out_rd_en) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IW'(N_REQ - 1);
      wd_q       <= '0;
      pkt_done_q <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      wd_q       <= wd_d;
      pkt_done_q <= pkt_done_d;
      tmo_q      <= tmo_d;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));

  a_rd_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.fifo_rd_en));

  a_state_matches_grant: assert property (@(posedge clk) disable iff (rst)
    ((state_q == GRANTED) == (grant_q != '0)));

endmodule
